gnr_attractor_ctrl: RTL
=======================

Name: gnr_attractor_ctrl

Overview:
Controller that sits at the driving end of the node interface of the gene-regulatory-network (GNR) accelerator. It generates initial network states and loads them into all nodes. It then steps the two state copies using Floyd tortoise/hare sequencing: s0 advances every other start_s0 cycle, s1 advances every start_s1 cycle. It compares the node state vectors to find the attractor and returns meet index, attractor state and period through a valid/ready result port.

Parameters:
NUM_NODES, 8, number of network nodes; width of the state vectors and of init_state
CNT_W, 16, width of the step and period counters and of num_states
MAX_STEPS, 4096, iteration limit for each phase before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a run; sampled in IDLE only
init_base  in  NUM_NODES  first initial state of the run
num_states  in  CNT_W  number of consecutive initial states to explore
reset_nos  out  1  load init_state into all nodes (s0, s1, pass)
start_s0  out  1  tortoise step enable to all nodes
start_s1  out  1  hare step enable to all nodes
init_state  out  NUM_NODES  bit i drives the init_state input of node i
s0_vec  in  NUM_NODES  concatenated node s0 outputs
s1_vec  in  NUM_NODES  concatenated node s1 outputs
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_init  out  NUM_NODES  initial state of this result
res_state  out  NUM_NODES  s0_vec captured when the period match occurs (attractor state)
res_meet  out  CNT_W  Floyd iterations k until s0_vec==s1_vec
res_period  out  CNT_W  attractor period; 0 on timeout
res_timeout  out  1  an iteration limit was reached
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset: state returns to IDLE and all outputs and counters go to 0. Reset applies mid-run with no drain; nodes are reloaded by the next LOAD.
- IDLE: on start=1, latch init_base as cur and num_states as remaining.
  - If num_states==0, pulse done on the next cycle and return to IDLE.
  - Otherwise go to LOAD.
- LOAD (1 cycle): reset_nos=1 and init_state=cur. Clear k and lam. Go to RUN_A.
- RUN_A and RUN_B (1 cycle each): start_s0=start_s1=1.
  - In RUN_A the nodes' pass=1, so s0 and s1 both step.
  - In RUN_B s0 holds (pass toggles back) and s1 steps again.
  - Then go to CHECK.
- CHECK (starts low): k<=k+1.
  - If s0_vec==s1_vec: capture k into res_meet and go to PER_STEP.
  - Else if k+1==MAX_STEPS: set the timeout flag and go to RESULT.
  - Else go to RUN_A.
  - After k iterations, s0=f^k(x) and s1=f^2k(x).
- PER_STEP (1 cycle): start_s1=1 only; s0 is frozen.
- PER_CHK: lam<=lam+1.
  - If s1_vec==s0_vec: res_period=lam+1, res_state=s0_vec, go to RESULT.
  - Else if lam+1==MAX_STEPS: set timeout, res_period=0, go to RESULT.
  - Else go to PER_STEP.
- RESULT: res_valid=1 with all res_* held stable until res_valid&&res_ready.
  - On handshake: cur<=cur+1 (wraps modulo 2^NUM_NODES), remaining<=remaining-1.
  - If remaining was 1: go to DONE. Otherwise go to LOAD the next cycle.
- DONE (1 cycle): done=1, then IDLE.
- reset_nos is never asserted in the same cycle as start_s0 or start_s1.
- start is ignored while busy.
- res_valid drops in the cycle after the handshake.
- Comparisons use registered node outputs; node latency is exactly 1 cycle.
- Latency for a fixed point, measured from the start-accept cycle t: LOAD t+1, RUN_A t+2, RUN_B t+3, CHECK t+4, PER_STEP t+5, PER_CHK t+6, res_valid at t+7.

Test Plan:
- Bench node model with f(x)=x, NUM_NODES=8, init_base=0x5A, num_states=1, res_ready=1 -> res_valid at cycle t+7, res_meet=1, res_period=1, res_state=0x5A, res_timeout=0, done pulse at t+8.
- Node model f(x)=x+1 mod 4 on 2 active bits, init 0 -> meet k=4 (f^4=f^8), res_period=4; reset_nos asserted exactly once per initial state.
- MAX_STEPS=8 with a model whose cycle has period 16 and transient 0 -> res_meet=16 is unreachable, so res_timeout=1, res_period=0, res_valid asserted after the 8th CHECK.
- num_states=3, init_base=0xFE, res_ready held low 5 cycles per result -> res_init sequence 0xFE, 0xFF, 0x00 (wrap); outputs stable while stalled; exactly 3 handshakes then done.
- num_states=0 -> no reset_nos, no res_valid; done pulse 1 cycle after start.
- rst asserted during RUN_B -> next cycle busy=0, start_s0=start_s1=0, res_valid=0; a following start reruns from LOAD with correct results.

Source files
------------

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: loads initial states into the GNR nodes and runs Floyd cycle detection to report meet index, attractor state and period.
module gnr_attractor_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_base,
  input  logic [CNT_W-1:0]     num_states,
  output logic                 reset_nos,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic [NUM_NODES-1:0] init_state,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_NODES-1:0] res_init,
  output logic [NUM_NODES-1:0] res_state,
  output logic [CNT_W-1:0]     res_meet,
  output logic [CNT_W-1:0]     res_period,
  output logic                 res_timeout,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [3:0] {IDLE, LOAD, RUN_A, RUN_B, CHECK, PER_STEP, PER_CHK, RESULT, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_NODES-1:0] cur_q, cur_d, cap_q, cap_d;
  logic [CNT_W-1:0] rem_q, rem_d, k_q, k_d, lam_q, lam_d, meet_q, meet_d, per_q, per_d;
  logic to_q, to_d;
  logic [CNT_W-1:0] k_inc, lam_inc;
  logic eq, k_lim, lam_lim, hs;
  assign k_inc = k_q + 1'b1;
  assign lam_inc = lam_q + 1'b1;
  assign eq = s0_vec == s1_vec;
  assign k_lim = k_inc == CNT_W'(MAX_STEPS);
  assign lam_lim = lam_inc == CNT_W'(MAX_STEPS);
  assign hs = state_q == RESULT && res_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      cap_q <= '0;
      rem_q <= '0;
      k_q <= '0;
      lam_q <= '0;
      meet_q <= '0;
      per_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      cap_q <= cap_d;
      rem_q <= rem_d;
      k_q <= k_d;
      lam_q <= lam_d;
      meet_q <= meet_d;
      per_q <= per_d;
      to_q <= to_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? (num_states == '0 ? DONE : LOAD) : IDLE;
      LOAD:     state_d = RUN_A;
      RUN_A:    state_d = RUN_B;
      RUN_B:    state_d = CHECK;
      CHECK:    state_d = eq ? PER_STEP : (k_lim ? RESULT : RUN_A);
      PER_STEP: state_d = PER_CHK;
      PER_CHK:  state_d = (eq || lam_lim) ? RESULT : PER_STEP;
      RESULT:   state_d = hs ? (rem_q == CNT_W'(1) ? DONE : LOAD) : RESULT;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Datapath next-state; result fields only change outside RESULT so they stay stable while stalled.
  always_comb begin
    cur_d = cur_q;
    cap_d = cap_q;
    rem_d = rem_q;
    k_d = k_q;
    lam_d = lam_q;
    meet_d = meet_q;
    per_d = per_q;
    to_d = to_q;
    if (state_q == IDLE && start) begin
      cur_d = init_base;
      rem_d = num_states;
    end
    if (state_q == LOAD) begin
      k_d = '0;
      lam_d = '0;
      meet_d = '0;
      per_d = '0;
      cap_d = '0;
      to_d = 1'b0;
    end
    if (state_q == CHECK) begin
      k_d = k_inc;
      meet_d = (eq || k_lim) ? k_inc : meet_q;
      to_d = !eq && k_lim;
    end
    if (state_q == PER_CHK) begin
      lam_d = lam_inc;
      per_d = eq ? lam_inc : '0;
      cap_d = eq ? s0_vec : cap_q;
      to_d = !eq && lam_lim;
    end
    if (hs) begin
      cur_d = cur_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end
  always_comb begin
    reset_nos = state_q == LOAD;
    start_s0 = state_q == RUN_A || state_q == RUN_B;
    start_s1 = state_q == RUN_A || state_q == RUN_B || state_q == PER_STEP;
    init_state = cur_q;
    res_valid = state_q == RESULT;
    res_init = cur_q;
    res_state = cap_q;
    res_meet = meet_q;
    res_period = per_q;
    res_timeout = to_q;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
endmodule
